// File: rtl/ov7670_stream_gen.sv
// OV7670-style camera source: generates PCLK/VSYNC/HREF/D in VGA RGB565
// timing with a selectable test pattern, two bytes per pixel.
module ov7670_stream_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_TOTAL   = 784,
    parameter int V_SYNC    = 3,
    parameter int V_BACK    = 17,
    parameter int V_ACTIVE  = 480,
    parameter int V_TOTAL   = 510,
    parameter int PCLK_HALF = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       pclk,
    output logic       vsync,
    output logic       href,
    output logic [7:0] d,
    output logic       frame_done,
    output logic [7:0] frame_cnt
);

    localparam int PH_W = $clog2(2*PCLK_HALF + 1);
    localparam int BW   = $clog2(2*H_TOTAL + 1);
    localparam int LW   = $clog2(V_TOTAL + 1);

    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(2*PCLK_HALF - 1);
    localparam logic [PH_W-1:0] PH_HALF   = PH_W'(PCLK_HALF);
    localparam logic [BW-1:0]   BYTE_LAST = BW'(2*H_TOTAL - 1);
    localparam logic [BW-1:0]   ACT_BYTES = BW'(2*H_ACTIVE);
    localparam logic [BW-1:0]   BAR_LAST  = BW'(H_ACTIVE/8 - 1);
    localparam logic [LW-1:0]   LINE_LAST = LW'(V_TOTAL - 1);
    localparam logic [LW-1:0]   SYNC_END  = LW'(V_SYNC);
    localparam logic [LW-1:0]   ACT_FIRST = LW'(V_SYNC + V_BACK);
    localparam logic [LW-1:0]   ACT_END   = LW'(V_SYNC + V_BACK + V_ACTIVE);

    typedef enum logic {IDLE, RUN} state_t;

    logic [PH_W-1:0] ph, ph_nx;
    logic            slot;
    state_t          state, state_nx;
    logic [LW-1:0]   line, line_nx;
    logic [BW-1:0]   bcnt, bcnt_nx;
    logic [1:0]      pat, pat_nx;
    logic [2:0]      bar_idx, bar_idx_nx;
    logic [BW-1:0]   bar_cnt, bar_cnt_nx;
    logic            fdone_nx;
    logic            vsync_nx, href_nx;
    logic [7:0]      d_nx;
    logic [7:0]      px, ypos, g;
    logic [15:0]     rgb;

    // A slot edge is where the phase wraps and pclk falls.
    assign slot  = (ph == PH_LAST);
    assign ph_nx = slot ? '0 : ph + 1'b1;

    // Free-running phase counter and registered pclk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph   <= '0;
            pclk <= 1'b0;
        end else begin
            ph   <= ph_nx;
            pclk <= (ph_nx >= PH_HALF);
        end
    end

    // State register: FSM state, raster counters, latched pattern, bar tracker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            line    <= '0;
            bcnt    <= '0;
            pat     <= '0;
            bar_idx <= '0;
            bar_cnt <= '0;
        end else begin
            state   <= state_nx;
            line    <= line_nx;
            bcnt    <= bcnt_nx;
            pat     <= pat_nx;
            bar_idx <= bar_idx_nx;
            bar_cnt <= bar_cnt_nx;
        end
    end

    // Next-state: raster advance on slot edges; frames always run to completion.
    always_comb begin
        state_nx   = state;
        line_nx    = line;
        bcnt_nx    = bcnt;
        pat_nx     = pat;
        fdone_nx   = 1'b0;
        bar_idx_nx = bar_idx;
        bar_cnt_nx = bar_cnt;
        if (slot) begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state_nx = RUN;
                        line_nx  = '0;
                        bcnt_nx  = '0;
                        pat_nx   = pattern_sel;
                    end
                end
                RUN: begin
                    if (bcnt == BYTE_LAST) begin
                        bcnt_nx = '0;
                        if (line == LINE_LAST) begin
                            line_nx  = '0;
                            fdone_nx = 1'b1;
                            if (enable) pat_nx   = pattern_sel;
                            else        state_nx = IDLE;
                        end else begin
                            line_nx = line + 1'b1;
                        end
                    end else begin
                        bcnt_nx = bcnt + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
            // Bar index follows the pixel being emitted; it steps on even bytes
            // once H_ACTIVE/8 pixels have gone by, avoiding a divider.
            if (bcnt_nx == '0) begin
                bar_idx_nx = '0;
                bar_cnt_nx = '0;
            end else if (!bcnt_nx[0]) begin
                if (bar_cnt == BAR_LAST) begin
                    bar_cnt_nx = '0;
                    bar_idx_nx = bar_idx + 1'b1;
                end else begin
                    bar_cnt_nx = bar_cnt + 1'b1;
                end
            end
        end
    end

    // Output decode from the upcoming raster position.
    always_comb begin
        px   = 8'(bcnt_nx >> 1);
        ypos = 8'(line_nx - ACT_FIRST);
        g    = px;
        case (pat_nx)
            2'd0: begin
                case (bar_idx_nx)
                    3'd0:    rgb = 16'hFFFF;
                    3'd1:    rgb = 16'hFFE0;
                    3'd2:    rgb = 16'h07FF;
                    3'd3:    rgb = 16'h07E0;
                    3'd4:    rgb = 16'hF81F;
                    3'd5:    rgb = 16'hF800;
                    3'd6:    rgb = 16'h001F;
                    default: rgb = 16'h0000;
                endcase
            end
            2'd1:    rgb = {g[7:3], g[7:2], g[7:3]};
            2'd2:    rgb = (px[3] ^ (|(ypos & 8'h08))) ? 16'hFFFF : 16'h0000;
            default: rgb = 16'hFFFF;
        endcase
        vsync_nx = (state_nx == RUN) && (line_nx < SYNC_END);
        href_nx  = (state_nx == RUN) && (line_nx >= ACT_FIRST) &&
                   (line_nx < ACT_END) && (bcnt_nx < ACT_BYTES);
        d_nx     = href_nx ? (bcnt_nx[0] ? rgb[7:0] : rgb[15:8]) : 8'h00;
    end

    // Pin registers: sync/data move only on slot edges; frame pulse is one clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync      <= 1'b0;
            href       <= 1'b0;
            d          <= 8'h00;
            frame_done <= 1'b0;
            frame_cnt  <= 8'h00;
        end else begin
            frame_done <= fdone_nx;
            if (fdone_nx) frame_cnt <= frame_cnt + 8'd1;
            if (slot) begin
                vsync <= vsync_nx;
                href  <= href_nx;
                d     <= d_nx;
            end
        end
    end

endmodule
